// File: rtl/risk_alarm_manager_if.sv
// Bus between the environmental processor / mission supervisor and risk_alarm_manager.
// The master side drives the risk sample stream and the supervisor controls; the slave side returns alarm status.
interface risk_alarm_manager_if;
  logic [15:0] risk_score;
  logic        risk_valid;
  logic        alarm_ack;
  logic        evt_clr;
  logic [1:0]  alarm_level;
  logic        alarm_req;
  logic [3:0]  alarm_cause;
  logic [1:0]  fsm_state;
  logic [15:0] evt_count;

  modport master (
    output risk_score, risk_valid, alarm_ack, evt_clr,
    input  alarm_level, alarm_req, alarm_cause, fsm_state, evt_count
  );

  modport slave (
    input  risk_score, risk_valid, alarm_ack, evt_clr,
    output alarm_level, alarm_req, alarm_cause, fsm_state, evt_count
  );
endinterface

// File: rtl/risk_alarm_manager.sv
// Debounced risk alarm manager: qualifies critical/warning conditions and runs a latched, acked alarm FSM.
// Optional ALARM-entry event counter enabled by defining RISK_EVT_CNT_EN.
module risk_alarm_manager #(
  parameter int unsigned DEBOUNCE  = 3,
  parameter int unsigned CLEAR_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  risk_alarm_manager_if.slave   bus
);
  localparam int unsigned CW = 8;
  localparam int unsigned EW = 16;
  localparam logic [CW-1:0] DEB_T = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CLR_T = CW'(CLEAR_CNT);

  typedef enum logic [1:0] {
    S_NORMAL = 2'd0,
    S_WARN   = 2'd1,
    S_ALARM  = 2'd2,
    S_ACKED  = 2'd3
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_crit_cnt, r_warn_cnt, r_ncrit_cnt, r_clr_cnt;
  logic [CW-1:0]  w_crit_nxt, w_warn_nxt, w_ncrit_nxt, w_clr_nxt;
  logic [1:0]     r_level, w_level_nxt;
  logic           r_req, w_req_nxt;
  logic [3:0]     r_cause, w_cause_nxt;
  logic [EW-1:0]  r_evt, w_evt_nxt;
  logic           w_v, w_crit, w_warn, w_clr;
  logic           w_crit_q, w_warn_q, w_ncrit_q, w_clr_q, w_crit_rise, w_alarm_entry;
  logic           w_unused_bits;

  assign w_v    = bus.risk_valid;
  assign w_crit = |bus.risk_score[15:12];
  assign w_warn = |bus.risk_score[15:8];
  assign w_clr  = ~w_warn;

  // Saturating debounce counter step: holds when invalid, zeroes when the condition is absent.
  function automatic logic [CW-1:0] f_cnt(input logic [CW-1:0] cnt, input logic v,
                                          input logic cond, input logic [CW-1:0] thr);
    if (!v)          return cnt;
    else if (!cond)  return '0;
    else if (cnt == thr) return cnt;
    else             return cnt + CW'(1);
  endfunction

  assign w_crit_nxt  = f_cnt(r_crit_cnt,  w_v, w_crit,  DEB_T);
  assign w_warn_nxt  = f_cnt(r_warn_cnt,  w_v, w_warn,  DEB_T);
  assign w_ncrit_nxt = f_cnt(r_ncrit_cnt, w_v, ~w_crit, DEB_T);
  assign w_clr_nxt   = f_cnt(r_clr_cnt,   w_v, w_clr,   CLR_T);

  assign w_crit_q  = w_v && (w_crit_nxt  == DEB_T);
  assign w_warn_q  = w_v && (w_warn_nxt  == DEB_T);
  assign w_ncrit_q = w_v && (w_ncrit_nxt == DEB_T);
  assign w_clr_q   = w_v && (w_clr_nxt   == CLR_T);
  // A counter still parked at threshold means crit never dropped, so it is not a new alarm.
  assign w_crit_rise = w_crit_q && (r_crit_cnt != DEB_T);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_NORMAL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NORMAL: begin
        if (w_crit_q)      w_state_nxt = S_ALARM;
        else if (w_warn_q) w_state_nxt = S_WARN;
      end
      S_WARN: begin
        if (w_crit_q)      w_state_nxt = S_ALARM;
        else if (w_clr_q)  w_state_nxt = S_NORMAL;
      end
      S_ALARM: begin
        if (bus.alarm_ack) w_state_nxt = (r_clr_cnt == CLR_T) ? S_NORMAL : S_ACKED;
      end
      S_ACKED: begin
        if (w_clr_q)          w_state_nxt = S_NORMAL;
        else if (w_ncrit_q)   w_state_nxt = S_WARN;
        else if (w_crit_rise) w_state_nxt = S_ALARM;
      end
      default: w_state_nxt = S_NORMAL;
    endcase
  end

  always_comb begin
    w_level_nxt   = 2'd2;
    w_req_nxt     = 1'b0;
    w_cause_nxt   = r_cause;
    w_alarm_entry = (w_state_nxt == S_ALARM) && (r_state != S_ALARM);
    case (w_state_nxt)
      S_NORMAL: w_level_nxt = 2'd0;
      S_WARN:   w_level_nxt = 2'd1;
      S_ALARM:  w_req_nxt   = 1'b1;
      default:  w_level_nxt = 2'd2;
    endcase
    if (w_alarm_entry)
      w_cause_nxt = bus.risk_score[15:12];
    else if (w_state_nxt == S_ALARM || w_state_nxt == S_ACKED) begin
      if (w_v) w_cause_nxt = r_cause | bus.risk_score[15:12];
    end else
      w_cause_nxt = '0;
  end

`ifdef RISK_EVT_CNT_EN
  // Clear dominates a coincident increment.
  always_comb begin
    w_evt_nxt = r_evt;
    if (bus.evt_clr)
      w_evt_nxt = '0;
    else if (w_alarm_entry && (r_evt != 16'hFFFF))
      w_evt_nxt = r_evt + EW'(1);
  end
  assign w_unused_bits = ^bus.risk_score[7:0];
`else
  assign w_evt_nxt     = '0;
  assign w_unused_bits = ^{bus.risk_score[7:0], bus.evt_clr};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crit_cnt  <= '0;
      r_warn_cnt  <= '0;
      r_ncrit_cnt <= '0;
      r_clr_cnt   <= '0;
      r_level     <= '0;
      r_req       <= 1'b0;
      r_cause     <= '0;
      r_evt       <= '0;
    end else begin
      r_crit_cnt  <= w_crit_nxt;
      r_warn_cnt  <= w_warn_nxt;
      r_ncrit_cnt <= w_ncrit_nxt;
      r_clr_cnt   <= w_clr_nxt;
      r_level     <= w_level_nxt;
      r_req       <= w_req_nxt;
      r_cause     <= w_cause_nxt;
      r_evt       <= w_evt_nxt;
    end
  end

  assign bus.alarm_level = r_level;
  assign bus.alarm_req   = r_req;
  assign bus.alarm_cause = r_cause;
  assign bus.fsm_state   = r_state;
  assign bus.evt_count   = r_evt;
endmodule
